// File: rtl/result_requant_drain_if.sv
// Result-matrix capture and requantized row-stream signals of the drain stage.
// The drain itself connects through the slave modport.
interface result_requant_drain_if #(
  parameter int N     = 8,
  parameter int ACC_W = 32,
  parameter int OUT_W = 8
);
  logic [N-1:0][N-1:0][ACC_W-1:0] i_c;
  logic                           i_validResult;
  logic [4:0]                     i_shift;
  logic [N-1:0][OUT_W-1:0]        o_data;
  logic [$clog2(N)-1:0]           o_rowIdx;
  logic                           o_valid;
  logic                           i_ready;
  logic                           o_last;

  modport slave (
    input  i_c, i_validResult, i_shift, i_ready,
    output o_data, o_rowIdx, o_valid, o_last
  );

  modport master (
    output i_c, i_validResult, i_shift, i_ready,
    input  o_data, o_rowIdx, o_valid, o_last
  );
endinterface

// File: rtl/result_requant_drain.sv
// Captures an NxN accumulator matrix, requantizes to OUT_W bits and drains it one row per beat.
// A result arriving while the buffer is still occupied is dropped and flagged in a sticky bit.
module result_requant_drain #(
  parameter int N     = 8,
  parameter int ACC_W = 32,
  parameter int OUT_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  result_requant_drain_if.slave bus,
  input  logic                  i_clrOverflow,
  output logic                  o_busy,
  output logic                  o_overflow
);
  // state | meaning
  // IDLE  | buffer empty, no beat presented
  // DRAIN | buffer full, presenting row row_q
  typedef enum logic {IDLE, DRAIN} state_t;

  localparam int RW = $clog2(N);
  localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX - (ACC_W+1)'(1);

  state_t                         state_q, state_d;
  logic [RW-1:0]                  row_q, row_d;
  logic [N-1:0][N-1:0][ACC_W-1:0] mat_q;
  logic [4:0]                     shift_q;
  logic                           xfer, last_row, buf_free, capture, drop;
  logic signed [ACC_W:0]          rnd;

  assign bus.o_valid  = (state_q == DRAIN);
  assign bus.o_rowIdx = row_q;
  assign bus.o_last   = bus.o_valid && last_row;
  assign o_busy       = (state_q == DRAIN);

  assign xfer     = bus.o_valid && bus.i_ready;
  assign last_row = (row_q == LAST_ROW);
  // the last-row transfer frees the buffer in the same cycle, so a pulse there is accepted
  assign buf_free = (state_q == IDLE) || (xfer && last_row);
  assign capture  = bus.i_validResult && buf_free;
  assign drop     = bus.i_validResult && !buf_free;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    unique case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = DRAIN;
          row_d   = '0;
        end
      end
      DRAIN: begin
        if (xfer) begin
          if (!last_row) begin
            row_d = row_q + 1'b1;
          end else begin
            row_d   = '0;
            state_d = capture ? DRAIN : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      mat_q      <= '0;
      shift_q    <= '0;
      o_overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      if (capture) begin
        mat_q   <= bus.i_c;
        shift_q <= bus.i_shift;
      end
      if (drop) begin
        o_overflow <= 1'b1;
      end else if (i_clrOverflow) begin
        o_overflow <= 1'b0;
      end
    end
  end

  // one extra bit of headroom keeps x + 2^(s-1) exact even at the int32 maximum
  assign rnd = (shift_q == '0) ? '0 : ((ACC_W+1)'(1) << (shift_q - 5'd1));

  for (genvar j = 0; j < N; j++) begin : g_rq
    logic signed [ACC_W:0] x, y;
    assign x = {mat_q[row_q][j][ACC_W-1], mat_q[row_q][j]};
    assign y = (x + rnd) >>> shift_q;
    assign bus.o_data[j] = (y > SAT_MAX) ? SAT_MAX[OUT_W-1:0] :
                           (y < SAT_MIN) ? SAT_MIN[OUT_W-1:0] : y[OUT_W-1:0];
  end
endmodule
